// File: rtl/dmem_access_unit_pkg.sv
// rtl/dmem_access_unit_pkg.sv - shared access-size encodings, FSM state codes and alignment helper
package dmem_access_unit_pkg;

    // Access size encoding shared with the control unit
    localparam logic [1:0] TAM_D = 2'b00;
    localparam logic [1:0] TAM_W = 2'b01;
    localparam logic [1:0] TAM_H = 2'b10;
    localparam logic [1:0] TAM_B = 2'b11;

    // Access sequencer states
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_RDW  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    // Natural alignment check: byte accesses can never be misaligned
    function automatic logic is_misaligned(input logic [1:0] tam, input logic [2:0] offset);
        logic bad;
        case (tam)
            TAM_D:   bad = (offset != 3'd0);
            TAM_W:   bad = (offset[1:0] != 2'd0);
            TAM_H:   bad = offset[0];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_access_unit_byte_lane_merge.sv
// rtl/dmem_access_unit_byte_lane_merge.sv - store lane merge and load extract/sign-extend datapath
module dmem_access_unit_byte_lane_merge
    import dmem_access_unit_pkg::*;
(
    input  logic [63:0] old_word,
    input  logic [63:0] wdata,
    input  logic [63:0] rd_word,
    input  logic [1:0]  tam,
    input  logic [2:0]  offset,
    output logic [63:0] merged,
    output logic [63:0] load_data
);

    logic [5:0]  shamt;
    logic [63:0] size_mask;
    logic [63:0] lane_mask;
    logic [63:0] shifted_wdata;
    logic [63:0] shifted_rd;

    // Byte offset converted to a bit shift; alignment is guaranteed upstream
    assign shamt = {offset, 3'b000};

    // Mask covering the low 1/2/4/8 bytes selected by the access size
    always_comb begin
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (tam)
            TAM_W:   size_mask = 64'h0000_0000_FFFF_FFFF;
            TAM_H:   size_mask = 64'h0000_0000_0000_FFFF;
            TAM_B:   size_mask = 64'h0000_0000_0000_00FF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign lane_mask     = size_mask << shamt;
    assign shifted_wdata = wdata << shamt;
    assign merged        = (old_word & ~lane_mask) | (shifted_wdata & lane_mask);

    assign shifted_rd = rd_word >> shamt;

    // Select the addressed lanes of the read word and sign-extend to 64 bits
    always_comb begin
        load_data = shifted_rd;
        case (tam)
            TAM_W:   load_data = {{32{shifted_rd[31]}}, shifted_rd[31:0]};
            TAM_H:   load_data = {{48{shifted_rd[15]}}, shifted_rd[15:0]};
            TAM_B:   load_data = {{56{shifted_rd[7]}},  shifted_rd[7:0]};
            default: load_data = shifted_rd;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - data-memory access sequencer: loads, sized stores via read-modify-write
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int MEM_AW = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        tam,
    input  logic [63:0]       addr,
    input  logic [63:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [63:0]       rdata,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic              req_we;
    logic [1:0]        req_tam;
    logic [MEM_AW+2:0] req_addr;
    logic [63:0]       req_wdata;
    logic [63:0]       word_q;
    logic [63:0]       merged;
    logic [63:0]       load_data;
    logic              unused_addr_hi;

    // Address bits above the RAM size are dropped so accesses wrap
    assign unused_addr_hi = ^addr[63:MEM_AW+3];

    // Choose the next step of the access from the registered state
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (is_misaligned(tam, addr[2:0])) begin
                        next_state = ST_ERR;
                    end else if (we && (tam == TAM_D)) begin
                        next_state = ST_WR;
                    end else begin
                        next_state = ST_RD;
                    end
                end
            end
            ST_RD:   next_state = ST_RDW;
            ST_RDW:  next_state = req_we ? ST_WR : ST_DONE;
            ST_WR:   next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            ST_ERR:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture the request only when idle so a held req cannot disturb an access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we    <= 1'b0;
            req_tam   <= TAM_D;
            req_addr  <= '0;
            req_wdata <= '0;
        end else if ((state == ST_IDLE) && req) begin
            req_we    <= we;
            req_tam   <= tam;
            req_addr  <= addr[MEM_AW+2:0];
            req_wdata <= wdata;
        end
    end

    // Capture the RAM word; loads also publish their result for the DONE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            rdata  <= '0;
        end else if (state == ST_RDW) begin
            word_q <= mem_rdata;
            if (!req_we) begin
                rdata <= load_data;
            end
        end
    end

    dmem_access_unit_byte_lane_merge u_merge (
        .old_word  (word_q),
        .wdata     (req_wdata),
        .rd_word   (mem_rdata),
        .tam       (req_tam),
        .offset    (req_addr[2:0]),
        .merged    (merged),
        .load_data (load_data)
    );

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE) || (state == ST_ERR);
    assign err       = (state == ST_ERR);
    assign mem_re    = (state == ST_RD);
    assign mem_we    = (state == ST_WR);
    assign mem_addr  = req_addr[MEM_AW+2:3];
    assign mem_wdata = (state != ST_WR)    ? 64'd0     :
                       (req_tam == TAM_D)  ? req_wdata : merged;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - scoreboard bench for dmem_access_unit with a behavioural RAM
module tb_dmem_access_unit;
    import dmem_access_unit_pkg::*;

    localparam int MEM_AW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [1:0]        tam = 2'b00;
    logic [63:0]       addr = 64'd0;
    logic [63:0]       wdata = 64'd0;
    logic              busy;
    logic              done;
    logic              err;
    logic [63:0]       rdata;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata = 64'd0;

    logic [63:0] ram    [0:(1<<MEM_AW)-1];
    logic [63:0] shadow [0:(1<<MEM_AW)-1];

    typedef struct {
        int          lat;
        logic        err;
        logic [63:0] rdata;
    } exp_t;

    typedef struct {
        logic [MEM_AW-1:0] wa;
        logic [63:0]       data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_rdata = 64'd0;

    dmem_access_unit #(.MEM_AW(MEM_AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .tam       (tam),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, want);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  {63'd0, busy},   64'd0);
        check({tag, "_done"},  {63'd0, done},   64'd0);
        check({tag, "_err"},   {63'd0, err},    64'd0);
        check({tag, "_re"},    {63'd0, mem_re}, 64'd0);
        check({tag, "_we"},    {63'd0, mem_we}, 64'd0);
        check({tag, "_rdata"}, rdata,           64'd0);
        check({tag, "_wdata"}, mem_wdata,       64'd0);
        check({tag, "_maddr"}, {56'd0, mem_addr}, 64'd0);
    endtask

    // Issue one request, push expectations from the bench model, then watch the DUT until done
    task automatic do_access(input logic w, input logic [1:0] t, input logic [63:0] a,
                             input logic [63:0] d, input bit hold);
        logic              mis;
        int                nb;
        int                off;
        int                lat;
        logic [MEM_AW-1:0] wi;
        logic [63:0]       word;
        logic [63:0]       res;
        logic              sgn;
        exp_t              e;
        wr_t               wr;
        exp_t              got_e;
        wr_t               got_w;
        int                re_cnt;
        int                we_cnt;
        int                re_cyc;
        bit                finished;

        case (t)
            TAM_D:   mis = (a[2:0] != 3'd0);
            TAM_W:   mis = (a[1:0] != 2'd0);
            TAM_H:   mis = a[0];
            default: mis = 1'b0;
        endcase
        nb  = 1 << (3 - int'(t));
        off = int'(a[2:0]);
        wi  = a[MEM_AW+2:3];
        lat = mis ? 1 : (!w ? 3 : ((t == TAM_D) ? 2 : 4));

        e.lat = lat;
        e.err = mis;
        e.rdata = last_rdata;
        if (!mis && w) begin
            word = shadow[wi];
            for (int b = 0; b < nb; b++) word[(off + b) * 8 +: 8] = d[b * 8 +: 8];
            shadow[wi] = word;
            wr.wa = wi;
            wr.data = word;
            wr_q.push_back(wr);
        end else if (!mis) begin
            word = shadow[wi];
            sgn = word[(off + nb) * 8 - 1];
            for (int b = 0; b < 8; b++)
                res[b * 8 +: 8] = (b < nb) ? word[(off + b) * 8 +: 8] : {8{sgn}};
            e.rdata = res;
            last_rdata = res;
        end
        exp_q.push_back(e);

        @(negedge clk);
        req = 1'b1; we = w; tam = t; addr = a; wdata = d;
        @(posedge clk);
        #1;
        if (hold) begin
            addr = a + 64'd8; tam = TAM_D; wdata = ~d; we = 1'b1;
        end else begin
            req = 1'b0;
        end

        re_cnt = 0; we_cnt = 0; re_cyc = 0; finished = 0;
        for (int cyc = 1; cyc <= 12 && !finished; cyc++) begin
            @(negedge clk);
            if (mem_re) begin
                re_cnt++;
                re_cyc = cyc;
            end
            if (mem_we) begin
                we_cnt++;
                check("we_cycle", 64'(cyc), 64'(lat - 1));
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 64'd1, 64'd0);
                end else begin
                    got_w = wr_q.pop_front();
                    check("mem_addr", {56'd0, mem_addr}, {56'd0, got_w.wa});
                    check("mem_wdata", mem_wdata, got_w.data);
                end
            end
            if (done) begin
                req = 1'b0;
                finished = 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    got_e = exp_q.pop_front();
                    check("done_latency", 64'(cyc), 64'(got_e.lat));
                    check("err", {63'd0, err}, {63'd0, got_e.err});
                    check("rdata", rdata, got_e.rdata);
                end
            end
        end
        if (!finished) check("done_timeout", 64'd0, 64'd1);
        req = 1'b0;
        check("re_count", 64'(re_cnt), (!mis && !(w && t == TAM_D)) ? 64'd1 : 64'd0);
        check("we_count", 64'(we_cnt), (!mis && w) ? 64'd1 : 64'd0);
        if (re_cnt > 0) check("re_cycle", 64'(re_cyc), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << MEM_AW); i++) shadow[i] = 64'd0;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Dword store then load
        do_access(1'b1, TAM_D, 64'h10, 64'h1122_3344_5566_7788, 0);
        check("ram_w2", ram[2], 64'h1122_3344_5566_7788);
        do_access(1'b0, TAM_D, 64'h10, 64'd0, 0);
        check("load_d", rdata, 64'h1122_3344_5566_7788);

        // Byte read-modify-write
        do_access(1'b1, TAM_D, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        do_access(1'b1, TAM_B, 64'h3, 64'hAB, 0);
        check("ram_w0_byte", ram[0], 64'hFFFF_FFFF_ABFF_FFFF);

        // Sign extension on word and half loads
        do_access(1'b1, TAM_D, 64'h8, 64'h0000_0000_8000_0000, 0);
        do_access(1'b0, TAM_W, 64'h8, 64'd0, 0);
        check("load_w_sext", rdata, 64'hFFFF_FFFF_8000_0000);
        do_access(1'b0, TAM_H, 64'hC, 64'd0, 0);
        check("load_h_zero", rdata, 64'd0);
        do_access(1'b0, TAM_B, 64'h3, 64'd0, 0);
        check("load_b_sext", rdata, 64'hFFFF_FFFF_FFFF_FFAB);

        // Misaligned accesses
        do_access(1'b1, TAM_W, 64'h6, 64'h5555_5555, 0);
        check("ram_w0_after_err", ram[0], 64'hFFFF_FFFF_ABFF_FFFF);
        do_access(1'b0, TAM_H, 64'h1, 64'd0, 0);

        // Request held while busy is ignored; accepted only when re-presented
        do_access(1'b1, TAM_D, 64'h20, 64'h0123_4567_89AB_CDEF, 0);
        do_access(1'b1, TAM_H, 64'h22, 64'hBEEF, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("held_req_ignored_busy", {63'd0, busy}, 64'd0);
            check("held_req_ignored_we", {63'd0, mem_we}, 64'd0);
        end
        check("ram_w4_half", ram[4], 64'h0123_4567_BEEF_CDEF);
        do_access(1'b1, TAM_D, 64'h28, 64'hCAFE, 0);
        check("ram_w5", ram[5], 64'hCAFE);

        // Address wrap: bits above the RAM size are ignored
        do_access(1'b0, TAM_D, 64'h10 + (64'd1 << (MEM_AW + 3)), 64'd0, 0);
        check("load_wrap", rdata, 64'h1122_3344_5566_7788);

        // Reset during RDW of a half store aborts the access
        @(negedge clk);
        req = 1'b1; we = 1'b1; tam = TAM_H; addr = 64'h30; wdata = 64'h1234;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        check("abort_no_we", {63'd0, mem_we}, 64'd0);
        rst_n = 1'b1;
        last_rdata = 64'd0;
        @(negedge clk);
        check("abort_still_idle", {63'd0, busy}, 64'd0);
        do_access(1'b0, TAM_W, 64'h8, 64'd0, 0);
        check("post_abort_load", rdata, 64'hFFFF_FFFF_8000_0000);

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("wr_q_empty", 64'(wr_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Responder side of the control unit's data-memory request interface (DMemWrite, tam, address from ALUOut, store data from RegB).
- Executes loads and sized stores (sd/sw/sh/sb) against a 64-bit-wide single-port synchronous RAM.
- Partial stores use read-modify-write with byte-lane merge. Loads return a sign-extended result for the MDR.
- Single request in flight; busy/done handshake back to the control FSM.

Parameters:
- MEM_AW, 8, RAM word-address width (RAM holds 2**MEM_AW 64-bit words)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  request strobe; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- tam  in  2  size: 00 dword, 01 word, 10 half, 11 byte
- addr  in  64  byte address
- wdata  in  64  store data, right-aligned (low bytes significant)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at completion (also on error)
- err  out  1  one-cycle pulse with done on misaligned access
- rdata  out  64  load result, sign-extended per tam
- mem_addr  out  MEM_AW  RAM word address = latched addr[MEM_AW+2:3]
- mem_re  out  1  RAM read enable; data valid on mem_rdata the next cycle
- mem_we  out  1  RAM write enable, full 64-bit word
- mem_wdata  out  64  RAM write data
- mem_rdata  in  64  RAM read data

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, done, err, mem_re, mem_we = 0. rdata, mem_wdata, mem_addr and the latched request registers = 0.
- States: IDLE, RD, RDW, WR, DONE, ERR.
- mem_re=1 only in RD; mem_we=1 only in WR. Both are decoded from the registered state.
- IDLE: on req=1, latch we, tam, addr, wdata.
  - Alignment rule: dword needs addr[2:0]=0, word needs addr[1:0]=0, half needs addr[0]=0; byte is always aligned.
  - Misaligned: go to ERR; no RAM access ever occurs.
  - Aligned load, or aligned store with tam!=00: go to RD.
  - Aligned store with tam=00: go to WR.
- RD -> RDW.
- RDW: capture mem_rdata into an internal word register.
  - Load: go to DONE.
  - Store: go to WR.
- WR:
  - For tam=00, mem_wdata = wdata.
  - Otherwise mem_wdata = captured word, with lanes starting at byte offset addr[2:0] replaced by the low 1/2/4 bytes of wdata.
  - Next state: DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - On a load, rdata is updated in this cycle and held until the next completed load.
  - rdata = selected bytes of the captured word, sign-extended to 64 bits.
- ERR: done=1, err=1 for exactly one cycle, then IDLE. rdata unchanged.
- Latency (accept edge = cycle 0):
  - Dword store: done in cycle 2.
  - Load: done in cycle 3.
  - Partial store: done in cycle 4.
  - Misaligned access: done/err in cycle 1.
- req while busy is ignored (not queued). The requester must hold req only until it sees busy.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after DONE.
- Reset mid-operation aborts the access. A pending WR does not occur if rst_n falls before its edge.
- addr bits above MEM_AW+2 are ignored (address wraps modulo RAM size).

Decomposition:
- Shared package (e.g. cpu_pkg):
  - tam encoding constants TAM_D=2'b00, TAM_W=2'b01, TAM_H=2'b10, TAM_B=2'b11, shared with the control unit.
  - Access-state enum.
- One natural sub-module: byte_lane_merge. It is purely combinational: inputs old word, wdata, tam, offset; outputs the merged word, plus the load extract/sign-extend path.

Test Plan:
- Dword store then load: store addr=0x10, wdata=0x1122334455667788 -> mem_we once, word 2 = 0x1122334455667788, done at cycle 2. Load dword 0x10 -> rdata=0x1122334455667788 at cycle 3.
- Byte RMW: RAM word 0 = 0xFFFFFFFFFFFFFFFF; store byte addr=0x3, wdata=0xAB -> mem_re at cycle 1, mem_we at cycle 3 with 0xFFFFFFFFABFFFFFF, done at cycle 4.
- Sign extension: word 1 = 0x0000000080000000; load word addr=0x8 -> rdata=0xFFFFFFFF80000000. Load half addr=0xC -> 0x0000000000000000.
- Misalignment: store word addr=0x6 -> err=done=1 at cycle 1, mem_re=mem_we=0 throughout, RAM unchanged. Also load half addr=0x1 -> err.
- Busy ignore: hold req=1 with different addr during a partial store -> exactly one access performed; the second request is accepted only when re-presented in IDLE.
- Reset abort: assert rst_n=0 during RDW of a half store -> no mem_we, all outputs 0. Next request completes normally.
